// File: rtl/md_pkt_pkg.sv
// Shared field layout and cell-coordinate constants for force packets and writeback records.
// Used by the sending cell-to-destination mapper and by force_pkt_receiver.
package md_pkt_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int CELL_ID_WIDTH     = 3;
  localparam int PARTICLE_ID_WIDTH = 7;
  localparam int NODE_ID_WIDTH     = 6;
  localparam int ID_WIDTH          = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH;
  localparam int WB_WIDTH          = ID_WIDTH + 3*DATA_WIDTH;
  localparam int PAYLOAD_WIDTH     = 3*DATA_WIDTH + PARTICLE_ID_WIDTH;
  localparam int PACKET_WIDTH      = PAYLOAD_WIDTH + NODE_ID_WIDTH;

  localparam logic [CELL_ID_WIDTH-1:0] CELL_1 = 3'b001;
  localparam logic [CELL_ID_WIDTH-1:0] CELL_2 = 3'b010;
  localparam logic [CELL_ID_WIDTH-1:0] CELL_3 = 3'b011;

  // Packet: {dest_id, particle_id, fz, fy, fx}
  localparam int PKT_FX_LSB   = 0;
  localparam int PKT_FY_LSB   = DATA_WIDTH;
  localparam int PKT_FZ_LSB   = 2*DATA_WIDTH;
  localparam int PKT_PID_LSB  = 3*DATA_WIDTH;
  localparam int PKT_DEST_LSB = PAYLOAD_WIDTH;

  // Writeback: {cellz, celly, cellx, particle_id, fz, fy, fx}
  localparam int WB_CELLX_LSB = PAYLOAD_WIDTH;
  localparam int WB_CELLY_LSB = PAYLOAD_WIDTH + CELL_ID_WIDTH;
  localparam int WB_CELLZ_LSB = PAYLOAD_WIDTH + 2*CELL_ID_WIDTH;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; outputs come straight from the head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/force_pkt_receiver.sv
// Receive endpoint: strips dest_id, rebuilds packets as home-cell writebacks, buffers them.
// Build macro FORCE_RX_MISROUTE_CNT_EN adds the dest_id check, drop path and misroute_cnt port.
module force_pkt_receiver
  import md_pkt_pkg::*;
#(
  parameter int NUM_CELLS         = 64,
  parameter int DATA_WIDTH        = 32,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int ID_WIDTH          = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH,
  parameter int WB_WIDTH          = ID_WIDTH + 3*DATA_WIDTH,
  parameter int NODE_ID_WIDTH     = $clog2(NUM_CELLS),
  parameter int PACKET_WIDTH      = 3*DATA_WIDTH + PARTICLE_ID_WIDTH + NODE_ID_WIDTH,
  parameter int HOME_CELL_ID      = 0,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PACKET_WIDTH-1:0] pkt_in,
  input  logic                    pkt_in_valid,
  output logic                    pkt_in_ready,
  output logic [WB_WIDTH-1:0]     wb_out,
  output logic                    wb_out_valid,
  input  logic                    wb_out_ready
`ifdef FORCE_RX_MISROUTE_CNT_EN
  ,
  output logic [15:0]             misroute_cnt
`endif
);

  localparam int PL_WIDTH = 3*DATA_WIDTH + PARTICLE_ID_WIDTH;

  logic                         accept;
  logic                         fifo_push;
  logic                         fifo_pop;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0] unused_fifo_count;
  logic [NODE_ID_WIDTH-1:0]     dest_id;
  logic [WB_WIDTH-1:0]          wb_rec;

  assign dest_id  = pkt_in[PACKET_WIDTH-1 -: NODE_ID_WIDTH];
  assign wb_rec   = {CELL_ID_WIDTH'(CELL_2), CELL_ID_WIDTH'(CELL_2), CELL_ID_WIDTH'(CELL_2),
                     pkt_in[PL_WIDTH-1:0]};
  assign accept   = pkt_in_valid & pkt_in_ready;
  assign fifo_pop = wb_out_valid & wb_out_ready;

  assign pkt_in_ready = ~fifo_full;
  assign wb_out_valid = ~fifo_empty;

`ifdef FORCE_RX_MISROUTE_CNT_EN
  logic is_home;
  logic misroute;

  assign is_home   = (dest_id == NODE_ID_WIDTH'(HOME_CELL_ID));
  assign fifo_push = accept & is_home;
  assign misroute  = accept & ~is_home;

  // A drop that coincides with a pop is not counted; only the pop takes effect.
  always_ff @(posedge clk) begin
    if (rst)
      misroute_cnt <= '0;
    else if (misroute && !fifo_pop && misroute_cnt != 16'hFFFF)
      misroute_cnt <= misroute_cnt + 16'd1;
  end
`else
  logic unused_dest;

  // Delivery is trusted by the network; dest_id is simply discarded.
  assign unused_dest = ^{dest_id, (dest_id == NODE_ID_WIDTH'(HOME_CELL_ID))};
  assign fifo_push   = accept;
`endif

  sync_fifo #(
    .WIDTH (WB_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (wb_rec),
    .pop       (fifo_pop),
    .pop_data  (wb_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

endmodule

// File: tb/tb_force_pkt_receiver.sv
// Self-checking bench for force_pkt_receiver: directed scenarios plus random traffic vs a queue model.
// Build with FORCE_RX_MISROUTE_CNT_EN defined to exercise the drop path and counter.
module tb_force_pkt_receiver;

  localparam int PW    = 109;
  localparam int WW    = 112;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pkt_in;
  logic          pkt_in_valid;
  logic          pkt_in_ready;
  logic [WW-1:0] wb_out;
  logic          wb_out_valid;
  logic          wb_out_ready;
`ifdef FORCE_RX_MISROUTE_CNT_EN
  logic [15:0]   misroute_cnt;
`endif

  force_pkt_receiver dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_in       (pkt_in),
    .pkt_in_valid (pkt_in_valid),
    .pkt_in_ready (pkt_in_ready),
    .wb_out       (wb_out),
    .wb_out_valid (wb_out_valid),
    .wb_out_ready (wb_out_ready)
`ifdef FORCE_RX_MISROUTE_CNT_EN
    ,
    .misroute_cnt (misroute_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Reference model: records waiting for the force cache, and the drop counter.
  logic [WW-1:0] q[$];
  int            mcnt = 0;

  function automatic logic [PW-1:0] mk_pkt(input int dest, input int pid,
                                           input logic [31:0] fx, fy, fz);
    logic [5:0] d;
    logic [6:0] p;
    d = dest[5:0];
    p = pid[6:0];
    return {d, p, fz, fy, fx};
  endfunction

  function automatic logic [WW-1:0] to_wb(input logic [PW-1:0] p);
    return {3'd2, 3'd2, 3'd2, p[102:96], p[95:64], p[63:32], p[31:0]};
  endfunction

  function automatic bit delivered(input logic [PW-1:0] p);
`ifdef FORCE_RX_MISROUTE_CNT_EN
    return p[108:103] == 6'd0;
`else
    return 1'b1;
`endif
  endfunction

  // Called at a falling edge: check outputs, drive inputs, advance model across the next rising edge.
  task automatic cyc(input logic v, input logic [PW-1:0] p, input logic r, output bit acc);
    bit pop;
    check("in_ready", 128'(pkt_in_ready), 128'(q.size() < DEPTH));
    check("wb_valid", 128'(wb_out_valid), 128'(q.size() > 0));
    if (q.size() > 0) check("wb_data", 128'(wb_out), 128'(q[0]));
`ifdef FORCE_RX_MISROUTE_CNT_EN
    check("misroute_cnt", 128'(misroute_cnt), 128'(mcnt));
`endif
    pkt_in_valid = v;
    pkt_in       = p;
    wb_out_ready = r;
    acc = v && (q.size() < DEPTH);
    pop = r && (q.size() > 0);
    if (pop) q.delete(0);
    if (acc) begin
      if (delivered(p)) q.push_back(to_wb(p));
      else if (!pop && mcnt < 65535) mcnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    pkt_in_valid = 1'b1;
    pkt_in       = mk_pkt(0, 99, 32'h1, 32'h2, 32'h3);
    wb_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    mcnt = 0;
  endtask

  bit            acc;
  bit            cur_v;
  logic [PW-1:0] cur_p;
  logic [PW-1:0] pk;

  initial begin
    rst          = 1'b1;
    pkt_in_valid = 1'b0;
    pkt_in       = '0;
    wb_out_ready = 1'b0;
    @(negedge clk);
    do_reset();
    check("rst_ready", 128'(pkt_in_ready), 128'(1));
    check("rst_valid", 128'(wb_out_valid), 128'(0));
`ifdef FORCE_RX_MISROUTE_CNT_EN
    check("rst_misroute", 128'(misroute_cnt), 128'(0));
`endif

    // Single packet and its exact writeback layout
    pk = mk_pkt(0, 5, 32'h3F800000, 32'h0, 32'hBF800000);
    cyc(1'b1, pk, 1'b0, acc);
    check("single_valid", 128'(wb_out_valid), 128'(1));
    check("single_wb", 128'(wb_out),
          {16'h0, 3'b010, 3'b010, 3'b010, 7'd5, 32'hBF800000, 32'h0, 32'h3F800000});
    cyc(1'b0, '0, 1'b1, acc);

`ifdef FORCE_RX_MISROUTE_CNT_EN
    for (int i = 0; i < 4; i++) cyc(1'b1, mk_pkt(1, i, 32'h11, 32'h22, 32'h33), 1'b0, acc);
    check("misroute_four", 128'(misroute_cnt), 128'(4));
    check("misroute_empty", 128'(wb_out_valid), 128'(0));
`endif

    // Fill to full; fifth packet is held until a slot frees
    for (int i = 1; i <= 5; i++) cyc(1'b1, mk_pkt(0, i, i, i + 100, i + 200), 1'b0, acc);
    check("full_ready", 128'(pkt_in_ready), 128'(0));
    pk = mk_pkt(0, 5, 5, 105, 205);
    acc = 0;
    for (int k = 0; k < 10 && !acc; k++) cyc(1'b1, pk, 1'b1, acc);
    check("fifth_accepted", 128'(acc), 128'(1));
    for (int k = 0; k < 6; k++) cyc(1'b0, '0, 1'b1, acc);
    check("drained", 128'(wb_out_valid), 128'(0));

    // Steady push/pop at occupancy 2 and at occupancy 1
    for (int i = 0; i < 2; i++) cyc(1'b1, mk_pkt(0, 20 + i, i, i, i), 1'b0, acc);
    for (int i = 0; i < 5; i++) cyc(1'b1, mk_pkt(0, 30 + i, i, 7, 9), 1'b1, acc);
    cyc(1'b0, '0, 1'b1, acc);
    for (int i = 0; i < 5; i++) cyc(1'b1, mk_pkt(0, 40 + i, 3, i, 9), 1'b1, acc);
    check("stream_valid", 128'(wb_out_valid), 128'(1));
    cyc(1'b0, '0, 1'b1, acc);

    // Reset with three entries buffered
    for (int i = 0; i < 3; i++) cyc(1'b1, mk_pkt(0, 50 + i, 1, 2, 3), 1'b0, acc);
    do_reset();
    check("rst_mid_valid", 128'(wb_out_valid), 128'(0));
    check("rst_mid_ready", 128'(pkt_in_ready), 128'(1));
    for (int k = 0; k < 3; k++) cyc(1'b0, '0, 1'b1, acc);

    // Random traffic; a presented packet is held until it transfers
    cur_v = 0;
    cur_p = '0;
    for (int k = 0; k < 2000; k++) begin
      if (!cur_v) begin
        cur_v = ($urandom_range(0, 3) != 0);
        cur_p = mk_pkt(($urandom_range(0, 3) == 0) ? $urandom_range(1, 63) : 0,
                       $urandom_range(0, 127), $urandom, $urandom, $urandom);
      end
      cyc(cur_v, cur_p, ($urandom_range(0, 9) < 6), acc);
      if (acc) cur_v = 0;
    end
    for (int k = 0; k < 6; k++) cyc(1'b0, '0, 1'b1, acc);
    check("final_empty", 128'(wb_out_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
